sc_backg_scheduler: RTL and testbench
=====================================

# sc_backg_scheduler

Sequencer for the scrolling background of the LED-matrix game. It drives the speed counter's count enable and clear, and watches the speed comparator's terminal flag. On every speed tick it issues one shift strobe, plus a new top-row pattern, to the background register bank that feeds the matrix controller. It also tracks a speed level used to select the comparator threshold.

## Interface
Parameters:
- DATAWIDTH_BUS, 8: row width in bits.
- LFSR_SEED, 8'hA5: row-generator LFSR value after reset; must be nonzero.
- LEVEL_STEP, 16: shifts per level increment; power of two, 2..128.
- LEVEL_MAX, 3: saturation value of the level output.

Ports:
- SC_BACKGSCHEDULER_CLOCK_50, in, 1: system clock. Only clock.
- SC_BACKGSCHEDULER_RESET_InLow, in, 1: reset. Synchronous, active-low.
- SC_BACKGSCHEDULER_start_InHigh, in, 1: debounced start button.
- SC_BACKGSCHEDULER_pause_InHigh, in, 1: level-sensitive pause request.
- SC_BACKGSCHEDULER_gameOver_InHigh, in, 1: collision or game-over flag.
- SC_BACKGSCHEDULER_T0_InLow, in, 1: speed comparator terminal flag; 0 means the threshold is reached.
- SC_BACKGSCHEDULER_upcount_OutLow, out, 1: speed counter enable; 0 means count.
- SC_BACKGSCHEDULER_clear_OutHigh, out, 1: one-cycle speed counter clear.
- SC_BACKGSCHEDULER_shift_OutLow, out, 1: one-cycle background shift strobe; 0 means shift.
- SC_BACKGSCHEDULER_newRow_OutBUS, out, DATAWIDTH_BUS: row inserted at the top. Valid only while the shift strobe is 0; 0 at all other times.
- SC_BACKGSCHEDULER_level_OutBUS, out, 2: speed level, 0..LEVEL_MAX.
- SC_BACKGSCHEDULER_busy_Out, out, 1: 1 in RUN, TICK, SHIFT and PAUSE.

## Operation
- States: IDLE, RUN, TICK, SHIFT, PAUSE, OVER.
- All outputs are registered and decoded from the state and the internal registers.
- Input priority in every non-IDLE state: gameOver > pause > T0.
- **IDLE:** upcount=1.
  - start=1 → RUN.
  - On that transition: clear shiftCount and level, and reload the LFSR with LFSR_SEED.
- **RUN:** upcount=0.
  - gameOver=1 → OVER.
  - Otherwise pause=1 → PAUSE.
  - Otherwise T0=0 → TICK.
- **TICK:** upcount=1, clear=1.
  - Always → SHIFT, or → OVER if gameOver=1.
- **SHIFT:** shift=0.
  - newRow = LFSR when shiftCount[0]==0; newRow = 0 when shiftCount[0]==1 (forced gap row).
  - LFSR advances one step.
  - shiftCount increments; it is 8 bits and wraps 255→0.
  - → RUN.
  - SHIFT always completes, even if gameOver or pause is asserted during it.
- **PAUSE:** upcount=1; the counter value is retained (no clear).
  - gameOver=1 → OVER.
  - pause=0 → RUN.
- **OVER:** upcount=1, shift=1, busy=0.
  - start=1 → IDLE.
  - A second start press is then needed to run again.
- **LFSR:** next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- **Level:** increments in SHIFT when (shiftCount+1) mod LEVEL_STEP == 0; saturates at LEVEL_MAX.

## Timing
- Reset values:
  - State IDLE, LFSR = LFSR_SEED, shiftCount = 0.
  - Outputs: upcount=1, clear=0, shift=1, newRow=0, level=0, busy=0.
- Reset wins over all inputs on the same edge. Reset taken mid-TICK or mid-SHIFT drops the strobe on the next cycle.
- start=1 sampled in IDLE → upcount=0 and busy=1 on the following cycle.
- T0=0 sampled in RUN → clear=1 on the next cycle → shift=0 one cycle after that. Latency from T0 sample to shift strobe is 2 cycles.
- clear and the shift strobe are each exactly one cycle wide. There is one shift per tick.
- T0 still 0 on entry to RUN after SHIFT is treated as a new tick. The counter is already clear, so this only occurs with a zero threshold.
- start held high continuously in OVER goes OVER→IDLE→RUN on consecutive cycles. The debounce upstream is relied on to avoid this.

## Configuration
- Macro BACKG_LEVEL_EN.
- Defined: level counter and saturation logic are compiled in as described above.
- Undefined: level logic is removed and level_OutBUS is tied to 0. LEVEL_STEP and LEVEL_MAX are ignored.

## Test plan
- Reset low for 2 cycles, then high → all outputs at their reset values; state IDLE; busy=0.
- start pulse, then T0=0 for 1 cycle at cycle 10 → clear=1 at cycle 11; shift=0 with newRow=8'hA5 at cycle 12; upcount=0 at cycle 13.
- Three consecutive ticks → newRow sequence 8'hA5, 8'h00, 8'h95.
- 16 ticks with BACKG_LEVEL_EN defined → level 0→1 on the 16th shift. 64 ticks → level holds at 3. Macro undefined → level stays 0.
- pause=1 in RUN with T0=0 on the same cycle → PAUSE, upcount=1, no clear and no shift. pause=0 → RUN resumes.
- gameOver=1 during TICK → no shift strobe; OVER entered next cycle. start → IDLE. start again → RUN with newRow restarting at 8'hA5.

Source files
------------

// File: rtl/sc_backg_scheduler.sv
// Scrolling-background sequencer: paces the speed counter, strobes row shifts and feeds new rows.
// Optional level tracking is compiled in with `define BACKG_LEVEL_EN.
module sc_backg_scheduler #(
    parameter int         DATAWIDTH_BUS = 8,
    parameter logic [7:0] LFSR_SEED     = 8'hA5,
    parameter int         LEVEL_STEP    = 16,
    parameter int         LEVEL_MAX     = 3
) (
    input  logic                     SC_BACKGSCHEDULER_CLOCK_50,
    input  logic                     SC_BACKGSCHEDULER_RESET_InLow,
    input  logic                     SC_BACKGSCHEDULER_start_InHigh,
    input  logic                     SC_BACKGSCHEDULER_pause_InHigh,
    input  logic                     SC_BACKGSCHEDULER_gameOver_InHigh,
    input  logic                     SC_BACKGSCHEDULER_T0_InLow,
    output logic                     SC_BACKGSCHEDULER_upcount_OutLow,
    output logic                     SC_BACKGSCHEDULER_clear_OutHigh,
    output logic                     SC_BACKGSCHEDULER_shift_OutLow,
    output logic [DATAWIDTH_BUS-1:0] SC_BACKGSCHEDULER_newRow_OutBUS,
    output logic [1:0]               SC_BACKGSCHEDULER_level_OutBUS,
    output logic                     SC_BACKGSCHEDULER_busy_Out
);

    typedef enum logic [2:0] {IDLE, RUN, TICK, SHIFT, PAUSE, OVER} state_t;

    state_t     state, stateNext;
    logic [7:0] lfsr;
    logic [7:0] shiftCount;

    logic                     upcountNext, clearNext, shiftNext, busyNext;
    logic [DATAWIDTH_BUS-1:0] newRowNext;

    wire clk       = SC_BACKGSCHEDULER_CLOCK_50;
    wire rstN      = SC_BACKGSCHEDULER_RESET_InLow;
    wire startIn   = SC_BACKGSCHEDULER_start_InHigh;
    wire pauseIn   = SC_BACKGSCHEDULER_pause_InHigh;
    wire overIn    = SC_BACKGSCHEDULER_gameOver_InHigh;
    wire thresholdN = SC_BACKGSCHEDULER_T0_InLow;
    wire runStart  = (state == IDLE) && startIn;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (startIn) stateNext = RUN;
            RUN:     if (overIn) stateNext = OVER;
                     else if (pauseIn) stateNext = PAUSE;
                     else if (!thresholdN) stateNext = TICK;
            TICK:    stateNext = overIn ? OVER : SHIFT;
            SHIFT:   stateNext = RUN;
            PAUSE:   if (overIn) stateNext = OVER;
                     else if (!pauseIn) stateNext = RUN;
            OVER:    if (startIn) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they appear registered, in step with it.
    always_comb begin
        upcountNext = (stateNext != RUN);
        clearNext   = (stateNext == TICK);
        shiftNext   = (stateNext != SHIFT);
        busyNext    = (stateNext == RUN) || (stateNext == TICK) ||
                      (stateNext == SHIFT) || (stateNext == PAUSE);
        newRowNext  = '0;
        if (stateNext == SHIFT && !shiftCount[0])
            newRowNext = DATAWIDTH_BUS'(lfsr);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state                            <= IDLE;
            lfsr                             <= LFSR_SEED;
            shiftCount                       <= 8'd0;
            SC_BACKGSCHEDULER_upcount_OutLow <= 1'b1;
            SC_BACKGSCHEDULER_clear_OutHigh  <= 1'b0;
            SC_BACKGSCHEDULER_shift_OutLow   <= 1'b1;
            SC_BACKGSCHEDULER_newRow_OutBUS  <= '0;
            SC_BACKGSCHEDULER_busy_Out       <= 1'b0;
        end else begin
            state                            <= stateNext;
            SC_BACKGSCHEDULER_upcount_OutLow <= upcountNext;
            SC_BACKGSCHEDULER_clear_OutHigh  <= clearNext;
            SC_BACKGSCHEDULER_shift_OutLow   <= shiftNext;
            SC_BACKGSCHEDULER_newRow_OutBUS  <= newRowNext;
            SC_BACKGSCHEDULER_busy_Out       <= busyNext;
            if (runStart) begin
                lfsr       <= LFSR_SEED;
                shiftCount <= 8'd0;
            end else if (state == SHIFT) begin
                lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                shiftCount <= shiftCount + 8'd1;
            end
        end
    end

`ifdef BACKG_LEVEL_EN
    logic [1:0] level;
    logic [7:0] countNext;

    assign countNext = shiftCount + 8'd1;

    always_ff @(posedge clk) begin
        if (!rstN || runStart) begin
            level <= 2'd0;
        end else if (state == SHIFT &&
                     (countNext & 8'(LEVEL_STEP - 1)) == 8'd0 &&
                     level < 2'(LEVEL_MAX)) begin
            level <= level + 2'd1;
        end
    end

    assign SC_BACKGSCHEDULER_level_OutBUS = level;
`else
    assign SC_BACKGSCHEDULER_level_OutBUS = 2'd0;
`endif

endmodule

// File: tb/tb_sc_backg_scheduler.sv
// Directed bench for sc_backg_scheduler: reset, tick timing, row sequence, level, pause and game-over.
// Level expectations follow whether BACKG_LEVEL_EN is defined for the build.
module tb_sc_backg_scheduler;

    logic       clk = 1'b0;
    logic       rstN, start, pause, gameOver, t0N;
    logic       upcountN, clear, shiftN, busy;
    logic [7:0] newRow;
    logic [1:0] level;

    int checks = 0;
    int errors = 0;

    logic [7:0] modelLfsr;
    logic [7:0] modelCount;
    logic [1:0] modelLevel;

    always #5 clk = ~clk;

    sc_backg_scheduler dut (
        .SC_BACKGSCHEDULER_CLOCK_50       (clk),
        .SC_BACKGSCHEDULER_RESET_InLow    (rstN),
        .SC_BACKGSCHEDULER_start_InHigh   (start),
        .SC_BACKGSCHEDULER_pause_InHigh   (pause),
        .SC_BACKGSCHEDULER_gameOver_InHigh(gameOver),
        .SC_BACKGSCHEDULER_T0_InLow       (t0N),
        .SC_BACKGSCHEDULER_upcount_OutLow (upcountN),
        .SC_BACKGSCHEDULER_clear_OutHigh  (clear),
        .SC_BACKGSCHEDULER_shift_OutLow   (shiftN),
        .SC_BACKGSCHEDULER_newRow_OutBUS  (newRow),
        .SC_BACKGSCHEDULER_level_OutBUS   (level),
        .SC_BACKGSCHEDULER_busy_Out       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic modelRestart();
        modelLfsr  = 8'hA5;
        modelCount = 8'd0;
        modelLevel = 2'd0;
    endtask

    // One full speed tick: T0 low for one cycle, then clear, then the shift strobe, then back in RUN.
    task automatic doTick(input string tag);
        logic [7:0] expRow;
        expRow = modelCount[0] ? 8'h00 : modelLfsr;
        t0N = 1'b0;
        step();
        t0N = 1'b1;
        check({tag, " clear"}, clear, 1);
        check({tag, " no early shift"}, shiftN, 1);
        step();
        check({tag, " shift"}, shiftN, 0);
        check({tag, " clear width"}, clear, 0);
        check({tag, " row"}, newRow, expRow);
        step();
        check({tag, " counting"}, upcountN, 0);
        check({tag, " shift width"}, shiftN, 1);
        check({tag, " row idle"}, newRow, 0);
        modelLfsr  = {modelLfsr[6:0], modelLfsr[7] ^ modelLfsr[5] ^ modelLfsr[4] ^ modelLfsr[3]};
        modelCount = modelCount + 8'd1;
`ifdef BACKG_LEVEL_EN
        if (modelCount[3:0] == 4'd0 && modelLevel < 2'd3) modelLevel = modelLevel + 2'd1;
`endif
        check({tag, " level"}, level, modelLevel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; start = 1'b0; pause = 1'b0; gameOver = 1'b0; t0N = 1'b1;
        modelRestart();
        step(); step();
        rstN = 1'b1;
        step();
        check("rst upcount", upcountN, 1);
        check("rst clear", clear, 0);
        check("rst shift", shiftN, 1);
        check("rst newRow", newRow, 0);
        check("rst level", level, 0);
        check("rst busy", busy, 0);

        // start -> RUN on the next cycle
        start = 1'b1;
        step();
        start = 1'b0;
        check("start upcount", upcountN, 0);
        check("start busy", busy, 1);
        repeat (5) step();
        check("run steady clear", clear, 0);

        // Rows A5, 00, 95, then on to the 16th and 64th shift
        doTick("tick1");
        doTick("tick2");
        doTick("tick3");
        repeat (12) doTick("tickN");
        check("level before 16th", level, 0);
        doTick("tick16");
`ifdef BACKG_LEVEL_EN
        check("level at 16", level, 1);
`else
        check("level at 16", level, 0);
`endif
        repeat (48) doTick("tickM");
`ifdef BACKG_LEVEL_EN
        check("level sat 64", level, 3);
`else
        check("level sat 64", level, 0);
`endif

        // pause wins over T0 on the same cycle
        pause = 1'b1;
        t0N   = 1'b0;
        step();
        check("pause upcount", upcountN, 1);
        check("pause clear", clear, 0);
        check("pause shift", shiftN, 1);
        check("pause busy", busy, 1);
        step();
        check("pause hold clear", clear, 0);
        check("pause hold shift", shiftN, 1);
        pause = 1'b0;
        t0N   = 1'b1;
        step();
        check("resume upcount", upcountN, 0);
        doTick("after pause");

        // gameOver during TICK: no strobe, OVER next cycle
        t0N = 1'b0;
        step();
        t0N = 1'b1;
        check("over tick clear", clear, 1);
        gameOver = 1'b1;
        step();
        gameOver = 1'b0;
        check("over no shift", shiftN, 1);
        check("over busy", busy, 0);
        check("over upcount", upcountN, 1);
        check("over clear", clear, 0);
        step();
        check("over stays", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("idle busy", busy, 0);
        check("idle upcount", upcountN, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("rerun busy", busy, 1);
        check("rerun upcount", upcountN, 0);
        modelRestart();
        doTick("rerun1");
        doTick("rerun2");

        // reset taken mid-TICK drops everything next cycle
        t0N = 1'b0;
        step();
        t0N  = 1'b1;
        check("mid tick clear", clear, 1);
        rstN = 1'b0;
        step();
        check("rst tick shift", shiftN, 1);
        check("rst tick clear", clear, 0);
        check("rst tick busy", busy, 0);
        check("rst tick upcount", upcountN, 1);
        rstN = 1'b1;
        step();
        check("post rst level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
